// File: rtl/smart_push.sv
// smart_push: in-order multi-lane push controller with credit tracking for a multi-write FIFO.
// Ports: clk, rst (async high), flush, valid_in/ready_out (upstream group),
//        push (FIFO write enables), free_in (slots released), credits (free-slot count).
// Option: define SMART_PUSH_BYPASS_EN to let slots freed this cycle be pushed this cycle.
module smart_push #(
    parameter int OUTPUT_PORTS = 2,
    parameter int DEPTH        = 8,
    localparam int FW = $clog2(OUTPUT_PORTS + 1),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [OUTPUT_PORTS-1:0] valid_in,
    output logic                    ready_out,
    output logic [OUTPUT_PORTS-1:0] push,
    input  logic [FW-1:0]           free_in,
    output logic [CW-1:0]           credits
);

    // Two extra bits so credits + free_in never wraps before saturation.
    localparam int SW = CW + 2;

    generate
        if (OUTPUT_PORTS < 1 || DEPTH < OUTPUT_PORTS) begin : g_bad_cfg
            $error("smart_push: need OUTPUT_PORTS >= 1 and DEPTH >= OUTPUT_PORTS");
        end
    endgenerate

    logic [OUTPUT_PORTS-1:0] sent;
    logic [OUTPUT_PORTS-1:0] pending;
    logic [SW-1:0]           avail;
    logic [SW-1:0]           npush;
    logic [SW-1:0]           sum;
    logic [CW-1:0]           credits_nxt;

    assign pending = valid_in & ~sent;

`ifdef SMART_PUSH_BYPASS_EN
    logic [SW-1:0] bypass_sum;
    assign bypass_sum = SW'(credits) + SW'(free_in);
    assign avail = (bypass_sum > SW'(DEPTH)) ? SW'(DEPTH) : bypass_sum;
`else
    assign avail = SW'(credits);
`endif

    // Lowest pending lanes take credits first; once credits run out every
    // higher pending lane is also refused, which keeps strict lane order.
    always_comb begin
        push  = '0;
        npush = '0;
        for (int i = 0; i < OUTPUT_PORTS; i++) begin
            if (pending[i] && (npush < avail)) begin
                push[i] = 1'b1;
                npush   = npush + SW'(1);
            end
        end
        if (flush) begin
            push  = '0;
            npush = '0;
        end
    end

    assign ready_out = !flush && ((pending & ~push) == '0);

    // npush never exceeds the available credits, so this cannot go negative.
    assign sum         = SW'(credits) + SW'(free_in) - npush;
    assign credits_nxt = (sum > SW'(DEPTH)) ? CW'(DEPTH) : sum[CW-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sent    <= '0;
            credits <= CW'(DEPTH);
        end else if (flush) begin
            sent    <= '0;
            credits <= CW'(DEPTH);
        end else begin
            sent    <= ready_out ? '0 : (sent | push);
            credits <= credits_nxt;
        end
    end

    // Returning more slots than were ever taken is an upstream bug.
    credit_overflow: assert property (
        @(posedge clk) disable iff (rst)
        !flush |-> (sum <= SW'(DEPTH))
    );

endmodule

// File: tb/tb_smart_push.sv
// tb_smart_push: directed scenarios plus randomized traffic checked against
// a lane-counting reference model of the push controller.
module tb_smart_push;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [1:0] valid_in;
    logic       ready_out;
    logic [1:0] push;
    logic [1:0] free_in;
    logic [2:0] credits;

    int checks   = 0;
    int failures = 0;

    smart_push #(.OUTPUT_PORTS(2), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .push      (push),
        .free_in   (free_in),
        .credits   (credits)
    );

    always #5 clk = ~clk;

    task automatic drv(input logic [1:0] v, input logic [1:0] f, input logic fl);
        valid_in = v;
        free_in  = f;
        flush    = fl;
        #1;
    endtask

    task automatic adv();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference: the first k pending lanes push, k = min(pending, credits).
    function automatic logic [1:0] m_push(
        input logic [1:0] v, input logic [1:0] s, input int cred,
        input int fr, input bit fl, output bit rdy);
        logic [1:0] pend;
        logic [1:0] res;
        int np, av, k, taken;
        pend = v & ~s;
        np   = $countones(pend);
        av   = cred;
`ifdef SMART_PUSH_BYPASS_EN
        av = (cred + fr > 4) ? 4 : cred + fr;
`endif
        k     = (np < av) ? np : av;
        res   = 2'b00;
        taken = 0;
        for (int i = 0; i < 2; i++) begin
            if (pend[i] && taken < k) begin
                res[i] = 1'b1;
                taken++;
            end
        end
        rdy = (k == np);
        if (fl) begin
            res = 2'b00;
            rdy = 1'b0;
        end
        return res;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        drv(2'b00, 2'b00, 1'b0);
        checks++;
        if (credits !== 3'd4) begin
            failures++; $display("FAIL reset_credits got=%0d exp=4", credits);
        end
        checks++;
        if (push !== 2'b00 || ready_out !== 1'b1) begin
            failures++; $display("FAIL reset_out push=%b rdy=%b exp 00/1", push, ready_out);
        end
        adv();
        rst = 1'b0;
        drv(2'b11, 2'b00, 1'b0);
        checks++;
        if (push !== 2'b11 || ready_out !== 1'b1) begin
            failures++; $display("FAIL first_group push=%b rdy=%b exp 11/1", push, ready_out);
        end
        adv();
        checks++;
        if (credits !== 3'd2) begin
            failures++; $display("FAIL first_credits got=%0d exp=2", credits);
        end
    endtask

    task automatic test_partial();
        drv(2'b01, 2'b00, 1'b0);
        adv();
        drv(2'b11, 2'b00, 1'b0);
        checks++;
        if (credits !== 3'd1 || push !== 2'b01 || ready_out !== 1'b0) begin
            failures++;
            $display("FAIL partial_c1 cr=%0d push=%b rdy=%b exp 1/01/0", credits, push, ready_out);
        end
        adv();
        checks++;
        if (credits !== 3'd0 || push !== 2'b00 || ready_out !== 1'b0) begin
            failures++;
            $display("FAIL partial_c2 cr=%0d push=%b rdy=%b exp 0/00/0", credits, push, ready_out);
        end
        adv();
        drv(2'b11, 2'b01, 1'b0);
`ifdef SMART_PUSH_BYPASS_EN
        checks++;
        if (push !== 2'b10 || ready_out !== 1'b1) begin
            failures++; $display("FAIL partial_c3 push=%b rdy=%b exp 10/1", push, ready_out);
        end
        adv();
        drv(2'b00, 2'b00, 1'b0);
        adv();
`else
        checks++;
        if (push !== 2'b00 || ready_out !== 1'b0) begin
            failures++; $display("FAIL partial_c3 push=%b rdy=%b exp 00/0", push, ready_out);
        end
        adv();
        drv(2'b11, 2'b00, 1'b0);
        checks++;
        if (push !== 2'b10 || ready_out !== 1'b1) begin
            failures++; $display("FAIL partial_c4 push=%b rdy=%b exp 10/1", push, ready_out);
        end
        adv();
`endif
        checks++;
        if (credits !== 3'd0) begin
            failures++; $display("FAIL partial_end_credits got=%0d exp=0", credits);
        end
    endtask

    task automatic test_hole();
        drv(2'b00, 2'b10, 1'b0);
        adv();
        drv(2'b11, 2'b00, 1'b0);
        checks++;
        if (push !== 2'b11 || ready_out !== 1'b1) begin
            failures++; $display("FAIL sent_cleared push=%b rdy=%b exp 11/1", push, ready_out);
        end
        adv();
        drv(2'b00, 2'b01, 1'b0);
        adv();
        drv(2'b10, 2'b00, 1'b0);
        checks++;
        if (credits !== 3'd1 || push !== 2'b10 || ready_out !== 1'b1) begin
            failures++;
            $display("FAIL hole cr=%0d push=%b rdy=%b exp 1/10/1", credits, push, ready_out);
        end
        adv();
        checks++;
        if (credits !== 3'd0) begin
            failures++; $display("FAIL hole_credits got=%0d exp=0", credits);
        end
    endtask

    task automatic test_simultaneous();
        drv(2'b00, 2'b10, 1'b0);
        adv();
        drv(2'b11, 2'b10, 1'b0);
        checks++;
        if (credits !== 3'd2 || push !== 2'b11 || ready_out !== 1'b1) begin
            failures++;
            $display("FAIL simul cr=%0d push=%b rdy=%b exp 2/11/1", credits, push, ready_out);
        end
        adv();
        checks++;
        if (credits !== 3'd2) begin
            failures++; $display("FAIL simul_credits got=%0d exp=2", credits);
        end
    endtask

    task automatic test_flush();
        drv(2'b01, 2'b00, 1'b0);
        adv();
        drv(2'b11, 2'b00, 1'b0);
        adv();
        drv(2'b11, 2'b00, 1'b1);
        checks++;
        if (push !== 2'b00 || ready_out !== 1'b0) begin
            failures++; $display("FAIL flush_cycle push=%b rdy=%b exp 00/0", push, ready_out);
        end
        adv();
        drv(2'b00, 2'b00, 1'b0);
        checks++;
        if (credits !== 3'd4) begin
            failures++; $display("FAIL flush_credits got=%0d exp=4", credits);
        end
        drv(2'b11, 2'b00, 1'b0);
        checks++;
        if (push !== 2'b11 || ready_out !== 1'b1) begin
            failures++; $display("FAIL flush_sent push=%b rdy=%b exp 11/1", push, ready_out);
        end
        adv();
    endtask

    task automatic test_bypass();
        drv(2'b11, 2'b00, 1'b0);
        adv();
        drv(2'b11, 2'b10, 1'b0);
`ifdef SMART_PUSH_BYPASS_EN
        checks++;
        if (push !== 2'b11 || ready_out !== 1'b1) begin
            failures++; $display("FAIL bypass_same push=%b rdy=%b exp 11/1", push, ready_out);
        end
        adv();
`else
        checks++;
        if (push !== 2'b00 || ready_out !== 1'b0) begin
            failures++; $display("FAIL bypass_off push=%b rdy=%b exp 00/0", push, ready_out);
        end
        adv();
        drv(2'b11, 2'b00, 1'b0);
        checks++;
        if (push !== 2'b11 || ready_out !== 1'b1) begin
            failures++; $display("FAIL bypass_next push=%b rdy=%b exp 11/1", push, ready_out);
        end
        adv();
`endif
        checks++;
        if (credits !== 3'd0) begin
            failures++; $display("FAIL bypass_credits got=%0d exp=0", credits);
        end
    endtask

    task automatic test_async_reset();
        drv(2'b00, 2'b10, 1'b0);
        adv();
        drv(2'b01, 2'b00, 1'b0);
        adv();
        drv(2'b11, 2'b00, 1'b0);
        adv();
        rst = 1'b1;
        #1;
        checks++;
        if (credits !== 3'd4 || push !== 2'b11 || ready_out !== 1'b1) begin
            failures++;
            $display("FAIL async_rst cr=%0d push=%b rdy=%b exp 4/11/1", credits, push, ready_out);
        end
        adv();
        rst = 1'b0;
        drv(2'b00, 2'b00, 1'b0);
    endtask

    task automatic test_random();
        int m_cred, fr, mx, k;
        logic [1:0] m_sent, cur_v, ep;
        bit er, fl, need_new;
        rst = 1'b1;
        drv(2'b00, 2'b00, 1'b0);
        adv();
        rst = 1'b0;
        m_cred   = 4;
        m_sent   = 2'b00;
        need_new = 1'b1;
        cur_v    = 2'b00;
        for (int n = 0; n < 600; n++) begin
            if (need_new) cur_v = 2'($urandom);
            mx = 4 - m_cred;
            if (mx > 2) mx = 2;
            fr = $urandom_range(0, mx);
            fl = ($urandom_range(0, 19) == 0);
            drv(cur_v, 2'(fr), fl);
            ep = m_push(cur_v, m_sent, m_cred, fr, fl, er);
            checks++;
            if (push !== ep || ready_out !== er) begin
                failures++;
                $display("FAIL rand_out n=%0d push=%b rdy=%b exp %b/%b", n, push, ready_out, ep, er);
            end
            checks++;
            if (credits !== 3'(m_cred)) begin
                failures++; $display("FAIL rand_credits n=%0d got=%0d exp=%0d", n, credits, m_cred);
            end
            if (fl) begin
                m_sent = 2'b00;
                m_cred = 4;
            end else begin
                k      = $countones(ep);
                m_cred = (m_cred + fr - k > 4) ? 4 : m_cred + fr - k;
                m_sent = er ? 2'b00 : (m_sent | ep);
            end
            need_new = er || fl;
            adv();
        end
        drv(2'b00, 2'b00, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst      = 1'b1;
        flush    = 1'b0;
        valid_in = 2'b00;
        free_in  = 2'b00;
        @(negedge clk);
        test_reset();
        test_partial();
        test_hole();
        test_simultaneous();
        test_flush();
        test_bypass();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
